// File: rtl/dense_layer_mac_array_if.sv
// rtl/dense_layer_mac_array_if.sv - sample stream, weight read port, bias write and result bundle
interface dense_layer_mac_array_if #(
    parameter int N_OUT  = 10,
    parameter int N_IN   = 128,
    parameter int DATA_W = 16
);
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int LANE_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     ena;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_first;
    logic                     in_last;
    logic signed [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]         w_addr;
    logic [N_OUT*DATA_W-1:0]  w_data;
    logic                     bias_we;
    logic [LANE_W-1:0]        bias_idx;
    logic signed [DATA_W-1:0] bias_wdata;
    logic                     out_valid;
    logic [N_OUT*DATA_W-1:0]  out_data;
    logic                     frame_err;
    logic                     busy;

    modport master (
        output ena, in_valid, in_first, in_last, in_data, w_data, bias_we, bias_idx, bias_wdata,
        input  in_ready, w_addr, out_valid, out_data, frame_err, busy
    );

    modport slave (
        input  ena, in_valid, in_first, in_last, in_data, w_data, bias_we, bias_idx, bias_wdata,
        output in_ready, w_addr, out_valid, out_data, frame_err, busy
    );
endinterface

// File: rtl/dense_layer_mac_array.sv
// rtl/dense_layer_mac_array.sv - N_OUT-lane signed MAC array for a streamed fully-connected layer
module dense_layer_mac_array #(
    parameter int N_OUT   = 10,
    parameter int N_IN    = 128,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int ACC_W   = 40,
    parameter bit RELU_EN = 1'b0
) (
    input logic clk,
    input logic rst,
    dense_layer_mac_array_if.slave bus
);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = IDX_W + 2;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, ACC, DRAIN1, DRAIN2, OUT} state_t;
    state_t state, state_nx;

    logic [IDX_W-1:0]           index, idx_cur, addr_d1;
    logic [CNT_W-1:0]           count, cnt_cur;
    logic                       mac_pend;
    logic signed [DATA_W-1:0]   data_d1;
    logic signed [ACC_W-1:0]    acc  [N_OUT];
    logic signed [DATA_W-1:0]   bias [N_OUT];
    logic signed [2*DATA_W-1:0] prod [N_OUT];
    logic signed [ACC_W-1:0]    sh   [N_OUT];
    logic signed [ACC_W:0]      sum  [N_OUT];
    logic [DATA_W-1:0]          sat  [N_OUT];
    logic [N_OUT*DATA_W-1:0]    result;
    logic signed [2*DATA_W-1:0] a_ext, w_ext;
    logic                       open, accept, start, take, counted;

    assign open         = (state == IDLE) || (state == ACC);
    assign bus.in_ready = open;
    assign bus.busy     = (state != IDLE);
    assign accept       = bus.ena && bus.in_valid && open;
    assign start        = accept && bus.in_first;
    assign take         = start || (accept && state == ACC);
    assign idx_cur      = start ? '0 : index;
    assign cnt_cur      = start ? '0 : count;
    assign counted      = take && (cnt_cur < CNT_W'(N_IN));

    // While stalled with a MAC pending, keep the memory pointed at that sample so w_data survives the stall.
    always_comb begin
        if (!bus.ena && mac_pend)
            bus.w_addr = addr_d1;
        else if (bus.in_valid && bus.in_first && open)
            bus.w_addr = '0;
        else
            bus.w_addr = index;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = bus.in_last ? DRAIN1 : ACC;
            ACC:     if (take && bus.in_last) state_nx = DRAIN1;
            DRAIN1:  state_nx = DRAIN2;
            DRAIN2:  state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        a_ext  = {{DATA_W{data_d1[DATA_W-1]}}, data_d1};
        w_ext  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_ext   = {{DATA_W{bus.w_data[i*DATA_W+DATA_W-1]}}, bus.w_data[i*DATA_W +: DATA_W]};
            prod[i] = a_ext * w_ext;
            sh[i]   = acc[i] >>> FRAC_W;
            sum[i]  = {sh[i][ACC_W-1], sh[i]} + {{(ACC_W + 1 - DATA_W){bias[i][DATA_W-1]}}, bias[i]};
            if (sum[i] > SAT_MAX)
                sat[i] = {1'b0, {(DATA_W - 1){1'b1}}};
            else if (sum[i] < SAT_MIN)
                sat[i] = {1'b1, {(DATA_W - 1){1'b0}}};
            else
                sat[i] = sum[i][DATA_W-1:0];
            if (RELU_EN && sat[i][DATA_W-1])
                sat[i] = '0;
            result[i*DATA_W +: DATA_W] = sat[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            index         <= '0;
            count         <= '0;
            addr_d1       <= '0;
            mac_pend      <= 1'b0;
            data_d1       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.frame_err <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                acc[i]  <= '0;
                bias[i] <= '0;
            end
        end else if (bus.ena) begin
            state         <= state_nx;
            mac_pend      <= counted;
            bus.out_valid <= (state == DRAIN2);
            if (counted) begin
                data_d1 <= bus.in_data;
                addr_d1 <= idx_cur;
            end
            if (take) begin
                index <= (idx_cur == IDX_W'(N_IN - 1)) ? idx_cur : idx_cur + 1'b1;
                count <= (cnt_cur > CNT_W'(N_IN)) ? cnt_cur : cnt_cur + 1'b1;
            end
            for (int i = 0; i < N_OUT; i++) begin
                if (start)
                    acc[i] <= '0;
                else if (mac_pend)
                    acc[i] <= acc[i] + {{(ACC_W - 2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
            end
            if (state == DRAIN2) begin
                bus.out_data  <= result;
                bus.frame_err <= (count != CNT_W'(N_IN));
            end
            if (bus.bias_we && (int'(bus.bias_idx) < N_OUT))
                bias[bus.bias_idx] <= bus.bias_wdata;
        end
    end
endmodule
